// File: rtl/data_unpacker.sv
// Word-to-byte serialiser: accepts one WORD_BYTES-wide word with a byte count
// and pushes its bytes LSB-first into a byte-wide TX FIFO.
module data_unpacker #(
  parameter int WORD_BYTES = 8,
  parameter int CNT_W      = 4
) (
  input  logic                    clk_pll,
  input  logic                    reset,
  input  logic [WORD_BYTES*8-1:0] in,
  input  logic [CNT_W-1:0]        in_bytes,
  input  logic                    input_valid,
  output logic                    input_ready,
  output logic [7:0]              FIFO_input_data,
  input  logic                    FIFO_full,
  output logic                    FIFO_push_data,
  output logic                    busy
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [WORD_BYTES-1:0][7:0]  word_buf;
  logic [CNT_W-1:0]            byte_idx;
  logic [CNT_W-1:0]            byte_cnt;
  logic [CNT_W-1:0]            in_cnt;
  logic                        last_byte;
  logic                        accept;

  // A count of 0 means a full word; out-of-range counts are clamped so the
  // index can never run past the buffer.
  always_comb begin
    in_cnt = in_bytes;
    if (in_bytes == '0 || in_bytes > CNT_W'(WORD_BYTES)) begin
      in_cnt = CNT_W'(WORD_BYTES);
    end
  end

  assign last_byte = (byte_idx == (byte_cnt - CNT_W'(1)));
  assign accept    = input_valid && input_ready;

  always_comb begin
    state_next      = state;
    input_ready     = 1'b0;
    busy            = 1'b0;
    FIFO_push_data  = 1'b0;
    FIFO_input_data = 8'h00;
    case (state)
      IDLE: begin
        input_ready = 1'b1;
        if (input_valid) begin
          state_next = SEND;
        end
      end
      SEND: begin
        busy            = 1'b1;
        FIFO_input_data = word_buf[byte_idx[IDX_W-1:0]];
        FIFO_push_data  = !FIFO_full;
        // Ready on the last push lets the next word follow without a bubble.
        input_ready     = !FIFO_full && last_byte;
        if (!FIFO_full && last_byte && !input_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_buf <= '0;
      byte_idx <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word_buf <= in;
        byte_cnt <= in_cnt;
        byte_idx <= '0;
      end else if (FIFO_push_data && last_byte) begin
        byte_idx <= '0;
      end else if (FIFO_push_data) begin
        byte_idx <= byte_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Bench for data_unpacker: per-cycle vector tables, a mid-word reset sequence
// and a randomized run against a byte-queue reference model.
module tb_data_unpacker;

  logic        clk_pll;
  logic        reset;
  logic [63:0] in_word;
  logic [3:0]  in_bytes;
  logic        input_valid;
  logic        input_ready;
  logic [7:0]  FIFO_input_data;
  logic        FIFO_full;
  logic        FIFO_push_data;
  logic        busy;

  int vectors;
  int miscompares;

  typedef struct {
    logic        valid;
    logic [63:0] word;
    logic [3:0]  nbytes;
    logic        full;
    logic        exp_push;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic        exp_ready;
  } vec_t;

  vec_t vec_q[$];

  data_unpacker #(.WORD_BYTES(8), .CNT_W(4)) dut (
    .clk_pll(clk_pll),
    .reset(reset),
    .in(in_word),
    .in_bytes(in_bytes),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .FIFO_input_data(FIFO_input_data),
    .FIFO_full(FIFO_full),
    .FIFO_push_data(FIFO_push_data),
    .busy(busy)
  );

  initial clk_pll = 1'b0;
  always #5 clk_pll = ~clk_pll;

  function automatic logic [7:0] byteOf(input logic [63:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives inputs just after the falling edge, well clear of the active edge.
  task automatic applyStimulus(input logic v, input logic [63:0] w, input logic [3:0] n, input logic f);
    @(negedge clk_pll);
    input_valid = v;
    in_word     = w;
    in_bytes    = n;
    FIFO_full   = f;
  endtask

  task automatic addVec(input logic v, input logic [63:0] w, input logic [3:0] n, input logic f,
                        input logic p, input logic [7:0] d, input logic b, input logic r);
    vec_t t;
    t.valid = v; t.word = w; t.nbytes = n; t.full = f;
    t.exp_push = p; t.exp_data = d; t.exp_busy = b; t.exp_ready = r;
    vec_q.push_back(t);
  endtask

  // One word with FIFO_full held low: accept cycle, n push cycles, idle cycle.
  task automatic addWord(input logic [63:0] w, input logic [3:0] n, input int count);
    addVec(1'b1, w, n, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < count; k++) begin
      addVec(1'b0, 64'h0, 4'd0, 1'b0, 1'b1, byteOf(w, k), 1'b1, k == count - 1);
    end
    addVec(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] w2;
    logic        full_pat[$];
    int          k;
    int          pi;
    logic        f;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_byte;
    int          words_left;
    int          cycles;
    logic        have_word;
    logic        accepted;
    logic [63:0] rw;
    logic [3:0]  rn;
    int          rcount;

    vectors     = 0;
    miscompares = 0;

    addWord(64'h8877665544332211, 4'd8, 8);

    w = 64'h8877665544332211;
    full_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    addVec(1'b1, w, 4'd8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    k = 0;
    pi = 0;
    while (k < 8) begin
      f = (pi < full_pat.size()) ? full_pat[pi] : 1'b0;
      addVec(1'b0, 64'h0, 4'd0, f, !f, byteOf(w, k), 1'b1, !f && (k == 7));
      if (!f) k++;
      pi++;
    end
    addVec(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    addWord(64'hFFFFFFFFFFAABBCC, 4'd3, 3);
    addWord(64'hFFFFFFFFFFAABBCC, 4'd0, 8);

    // Back-to-back: second word held on the inputs while the first drains.
    w  = 64'h0807060504030201;
    w2 = 64'h100F0E0D0C0B0A09;
    addVec(1'b1, w, 4'd8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      addVec(1'b1, w2, 4'd8, 1'b0, 1'b1, byteOf(w, i), 1'b1, i == 7);
    end
    for (int i = 0; i < 8; i++) begin
      addVec(1'b0, 64'h0, 4'd0, 1'b0, 1'b1, byteOf(w2, i), 1'b1, i == 7);
    end
    addVec(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    reset       = 1'b1;
    input_valid = 1'b0;
    in_word     = 64'h0;
    in_bytes    = 4'd0;
    FIFO_full   = 1'b0;
    #1;
    checkOutput("reset_push", FIFO_push_data, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ready", input_ready, 1'b1);
    checkOutput("reset_data", FIFO_input_data, 8'h00);
    @(negedge clk_pll);
    reset = 1'b0;

    $display("[TB] applying %0d table vectors", vec_q.size());
    foreach (vec_q[i]) begin
      applyStimulus(vec_q[i].valid, vec_q[i].word, vec_q[i].nbytes, vec_q[i].full);
      #1;
      checkOutput($sformatf("tbl%0d_push", i), FIFO_push_data, vec_q[i].exp_push);
      checkOutput($sformatf("tbl%0d_busy", i), busy, vec_q[i].exp_busy);
      checkOutput($sformatf("tbl%0d_ready", i), input_ready, vec_q[i].exp_ready);
      if (vec_q[i].exp_busy) begin
        checkOutput($sformatf("tbl%0d_data", i), FIFO_input_data, vec_q[i].exp_data);
      end
    end

    // Reset after the third push of an 8-byte word.
    w = 64'h8877665544332211;
    applyStimulus(1'b1, w, 4'd8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 64'h0, 4'd0, 1'b0);
      #1;
      checkOutput($sformatf("mid_data%0d", i), FIFO_input_data, byteOf(w, i));
    end
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_push", FIFO_push_data, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_ready", input_ready, 1'b1);
    checkOutput("mid_rst_data", FIFO_input_data, 8'h00);
    @(negedge clk_pll);
    #1;
    checkOutput("mid_rst_hold_push", FIFO_push_data, 1'b0);
    reset = 1'b0;
    w2 = 64'h00000000DEADBEEF;
    applyStimulus(1'b1, w2, 4'd4, 1'b0);
    #1;
    checkOutput("post_rst_ready", input_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 64'h0, 4'd0, 1'b0);
      #1;
      checkOutput($sformatf("post_rst_push%0d", i), FIFO_push_data, 1'b1);
      checkOutput($sformatf("post_rst_data%0d", i), FIFO_input_data, byteOf(w2, i));
    end
    applyStimulus(1'b0, 64'h0, 4'd0, 1'b0);
    #1;
    checkOutput("post_rst_idle_busy", busy, 1'b0);

    // Randomized run: the model is simply the ordered list of bytes every
    // offered word should produce.
    words_left = 200;
    have_word  = 1'b0;
    cycles     = 0;
    rw         = 64'h0;
    rn         = 4'd0;
    while ((words_left > 0 || exp_q.size() > 0) && cycles < 20000) begin
      @(negedge clk_pll);
      if (!have_word && words_left > 0 && ($urandom % 4) != 0) begin
        rw     = {$urandom, $urandom};
        rn     = 4'($urandom_range(0, 8));
        rcount = (rn == 4'd0) ? 8 : int'(rn);
        for (int i = 0; i < rcount; i++) exp_q.push_back(byteOf(rw, i));
        have_word = 1'b1;
      end
      input_valid = have_word;
      in_word     = have_word ? rw : {$urandom, $urandom};
      in_bytes    = rn;
      FIFO_full   = ($urandom % 10) < 3;
      #1;
      accepted = input_valid && input_ready;
      if (busy) begin
        checkOutput("rnd_push_vs_full", FIFO_push_data, !FIFO_full);
      end
      if (FIFO_push_data) begin
        if (exp_q.size() == 0) begin
          checkOutput("rnd_unexpected_push", 1'b1, 1'b0);
        end else begin
          exp_byte = exp_q.pop_front();
          checkOutput("rnd_data", FIFO_input_data, exp_byte);
        end
      end
      @(posedge clk_pll);
      if (accepted) begin
        have_word = 1'b0;
        words_left--;
      end
      cycles++;
    end
    checkOutput("rnd_words_left", 64'(words_left), 64'd0);
    checkOutput("rnd_bytes_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
